// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit serializer.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
    StParity = 3'd3,
`endif
    StStop   = 3'd4
  } tx_state_e;

  localparam logic [1:0] WordLen5 = 2'b00;
  localparam logic [1:0] WordLen6 = 2'b01;
  localparam logic [1:0] WordLen7 = 2'b10;
  localparam logic [1:0] WordLen8 = 2'b11;

  // Line status register bit positions
  localparam int unsigned LsrThre = 5;
  localparam int unsigned LsrTemt = 6;

  // Index of the last data bit for a word_len encoding (5 bits -> 4 ... 8 bits -> 7)
  function automatic logic [2:0] last_bit_idx(input logic [1:0] word_len);
    return {1'b1, word_len};
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO with flush and occupancy count.
module uart_tx_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   wr_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   rd_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] cnt_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;
  localparam logic [AddrW-1:0] PtrOne  = AddrW'(1);
  localparam logic [CntW-1:0]  CntOne  = CntW'(1);
  localparam logic [CntW-1:0]  CntFull = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             wr_en, rd_en;

  assign full_o  = (cnt_q == CntFull);
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  // A flush overrides any push or pop in the same cycle
  assign wr_en = wr_i && !full_o && !clr_i;
  assign rd_en = rd_i && !empty_o && !clr_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + PtrOne;
      if (rd_en) rptr_q <= rptr_q + PtrOne;
      if (wr_en && !rd_en) begin
        cnt_q <= cnt_q + CntOne;
      end else if (rd_en && !wr_en) begin
        cnt_q <= cnt_q - CntOne;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: byte FIFO feeding a start/data/parity/stop frame serializer.
// Define UART_TX_PARITY_EN to include the parity bit logic and PARITY state.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [7:0]                  data_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic                        fifo_clr_i,
  input  logic [DIV_W-1:0]            div_i,
  input  logic [1:0]                  word_len_i,
  input  logic                        stop2_i,
  input  logic                        parity_en_i,
  input  logic                        parity_even_i,
  output logic                        tx_o,
  output logic                        thre_o,
  output logic                        temt_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o
);

  localparam logic [DIV_W-1:0] DivOne = DIV_W'(1);

  tx_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       sh_q, sh_d;
  logic [2:0]       bit_q, bit_d;
  logic [2:0]       last_q, last_d;
  logic             stop2_q, stop2_d;
  logic             second_q, second_d;
  logic             tx_q, tx_d;
  logic             busy_q;
  logic             rdy_en_q;

  logic [7:0]       fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic             pop, push, can_start, start_frame, bit_done;
  logic [DIV_W-1:0] div_eff;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
  logic par_en_q, par_en_d;
  logic par_even_q, par_even_d;
`else
  logic unused_parity;
  assign unused_parity = parity_en_i ^ parity_even_i;
`endif

  // rdy_en_q keeps ready_o low while in reset and until the first edge after release
  assign ready_o   = rdy_en_q && !fifo_full && !fifo_clr_i;
  assign push      = valid_i && ready_o;
  assign can_start = !fifo_empty && !fifo_clr_i;
  assign bit_done  = (cnt_q == '0);
  assign div_eff   = (div_i == '0) ? DivOne : div_i;

  uart_tx_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (fifo_clr_i),
    .wr_i    (push),
    .wdata_i (data_i),
    .rd_i    (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .cnt_o   (fifo_cnt_o)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    sh_d        = sh_q;
    bit_d       = bit_q;
    last_d      = last_q;
    stop2_d     = stop2_q;
    second_d    = second_q;
    pop         = 1'b0;
    start_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d       = par_q;
    par_en_d    = par_en_q;
    par_even_d  = par_even_q;
`endif

    if (state_q != StIdle) cnt_d = bit_done ? div_q - DivOne : cnt_q - DivOne;

    unique case (state_q)
      StIdle:  start_frame = can_start;
      StStart: if (bit_done) state_d = StData;
      StData: begin
        if (bit_done) begin
          sh_d = {1'b0, sh_q[7:1]};
`ifdef UART_TX_PARITY_EN
          par_d = par_q ^ sh_q[0];
`endif
          if (bit_q == last_q) begin
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? StParity : StStop;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: if (bit_done) state_d = StStop;
`endif
      StStop: begin
        if (bit_done) begin
          if (stop2_q && !second_q) begin
            second_d = 1'b1;
          end else if (can_start) begin
            // Chain straight into the next frame so no idle bit appears
            start_frame = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_frame) begin
      pop      = 1'b1;
      state_d  = StStart;
      div_d    = div_eff;
      cnt_d    = div_eff - DivOne;
      sh_d     = fifo_rdata;
      bit_d    = 3'd0;
      last_d   = last_bit_idx(word_len_i);
      stop2_d  = stop2_i;
      second_d = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d      = 1'b0;
      par_en_d   = parity_en_i;
      par_even_d = parity_even_i;
`endif
    end
  end

  // Line level is registered from the current state, so it lags the FSM by one cycle
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = sh_q[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = par_q ^ ~par_even_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      div_q    <= DivOne;
      sh_q     <= '0;
      bit_q    <= '0;
      last_q   <= '0;
      stop2_q  <= 1'b0;
      second_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      sh_q     <= sh_d;
      bit_q    <= bit_d;
      last_q   <= last_d;
      stop2_q  <= stop2_d;
      second_q <= second_d;
      tx_q     <= tx_d;
      busy_q   <= (state_q != StIdle);
      rdy_en_q <= 1'b1;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_q      <= 1'b0;
      par_en_q   <= 1'b0;
      par_even_q <= 1'b0;
    end else begin
      par_q      <= par_d;
      par_en_q   <= par_en_d;
      par_even_q <= par_even_d;
    end
  end
`endif

  assign tx_o   = tx_q;
  assign thre_o = fifo_empty;
  // busy_q covers the final stop cycle still on the line after the FSM returns to idle
  assign temt_o = fifo_empty && (state_q == StIdle) && !busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: frame-level reference model plus literal scenarios.
module tb_uart_tx_serializer;

  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned DIV_W      = 16;

  logic                        clk_i;
  logic                        rst_ni;
  logic [7:0]                  data_i;
  logic                        valid_i;
  logic                        ready_o;
  logic                        fifo_clr_i;
  logic [DIV_W-1:0]            div_i;
  logic [1:0]                  word_len_i;
  logic                        stop2_i;
  logic                        parity_en_i;
  logic                        parity_even_i;
  logic                        tx_o;
  logic                        thre_o;
  logic                        temt_o;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_serializer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (DIV_W)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .data_i        (data_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .fifo_clr_i    (fifo_clr_i),
    .div_i         (div_i),
    .word_len_i    (word_len_i),
    .stop2_i       (stop2_i),
    .parity_en_i   (parity_en_i),
    .parity_even_i (parity_even_i),
    .tx_o          (tx_o),
    .thre_o        (thre_o),
    .temt_o        (temt_o),
    .fifo_cnt_o    (fifo_cnt_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, the line as a queue of per-cycle levels.
  logic [7:0] mq[$];
  logic       mline[$];
  int         mrem;
  bit         minit;
  bit         mact;
  logic       exp_tx;
  int         md, mnb, mns;
  logic [7:0] mb;
  logic       mp, mpush;

  initial begin : model_proc
    mrem = 0; minit = 0; mact = 0; exp_tx = 1'b1;
    forever begin
      @(posedge clk_i);
      if (!rst_ni) begin
        mq.delete();
        mline.delete();
        mrem   = 0;
        minit  = 0;
        mact   = 0;
        exp_tx = 1'b1;
      end else begin
        mpush  = valid_i && minit && (mq.size() < FIFO_DEPTH) && !fifo_clr_i;
        mact   = (mline.size() > 0);
        exp_tx = mact ? mline.pop_front() : 1'b1;
        if (mrem > 0) mrem--;
        if (fifo_clr_i) begin
          mq.delete();
        end else if (mrem == 0 && mq.size() > 0) begin
          mb  = mq.pop_front();
          md  = (div_i == 0) ? 1 : int'(div_i);
          mnb = 5 + int'(word_len_i);
          mns = stop2_i ? 2 : 1;
          repeat (md) mline.push_back(1'b0);
          for (int i = 0; i < mnb; i++) repeat (md) mline.push_back(mb[i]);
`ifdef UART_TX_PARITY_EN
          if (parity_en_i) begin
            mp = !parity_even_i;
            for (int i = 0; i < mnb; i++) mp = mp ^ mb[i];
            repeat (md) mline.push_back(mp);
          end
`endif
          repeat (mns * md) mline.push_back(1'b1);
          mrem = mline.size();
        end
        if (mpush) mq.push_back(data_i);
        minit = 1;
      end
      #1;
      chk("tx_o", 64'(tx_o), 64'(exp_tx));
      chk("thre_o", 64'(thre_o), 64'(mq.size() == 0));
      chk("temt_o", 64'(temt_o), 64'(mq.size() == 0 && mrem == 0 && !mact));
      chk("ready_o", 64'(ready_o), 64'(minit && mq.size() < FIFO_DEPTH && !fifo_clr_i));
      chk("fifo_cnt_o", 64'(fifo_cnt_o), 64'(mq.size()));
    end
  end

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk_i);
    data_i  = b;
    valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  // Push one byte into an idle transmitter and capture n line samples from the start bit
  task automatic send_capture(input logic [7:0] b, input int n, output logic pre,
                              output logic [63:0] cap);
    push_byte(b);
    @(posedge clk_i); #2;
    pre = tx_o;
    cap = '0;
    @(posedge clk_i); #2;
    for (int i = 0; i < n; i++) begin
      cap = {cap[62:0], tx_o};
      @(posedge clk_i); #2;
    end
  endtask

  task automatic wait_temt(input int max);
    int n;
    n = 0;
    while (temt_o !== 1'b1 && n < max) begin
      @(posedge clk_i); #2;
      n++;
    end
    chk("drain_temt", 64'(temt_o), 64'd1);
  endtask

  task automatic set_cfg(input int div, input logic [1:0] wl, input logic s2,
                         input logic pen, input logic peven);
    @(negedge clk_i);
    div_i         = DIV_W'(div);
    word_len_i    = wl;
    stop2_i       = s2;
    parity_en_i   = pen;
    parity_even_i = peven;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic        pre;
    logic [63:0] cap;
    rst_ni = 1'b0; valid_i = 1'b0; data_i = '0; fifo_clr_i = 1'b0;
    div_i = DIV_W'(4); word_len_i = 2'b11; stop2_i = 1'b0;
    parity_en_i = 1'b0; parity_even_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_tx", 64'(tx_o), 64'd1);
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_temt", 64'(temt_o), 64'd1);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // 8N1, div 4, 0x55
    send_capture(8'h55, 40, pre, cap);
    chk("8n1_start_delay", 64'(pre), 64'd1);
    chk("8n1_frame", cap, 64'h0F0F0F0F0F);
    chk("8n1_tx_idle", 64'(tx_o), 64'd1);
    chk("8n1_temt", 64'(temt_o), 64'd1);

`ifdef UART_TX_PARITY_EN
    set_cfg(2, 2'b10, 1'b0, 1'b1, 1'b1);
    send_capture(8'h41, 20, pre, cap);
    chk("7e1_frame", cap, 64'h30033);
    set_cfg(2, 2'b10, 1'b0, 1'b1, 1'b0);
    send_capture(8'h41, 20, pre, cap);
    chk("7o1_frame", cap, 64'h3003F);
`else
    set_cfg(2, 2'b10, 1'b0, 1'b1, 1'b1);
    send_capture(8'h41, 18, pre, cap);
    chk("7n1_parity_ignored", cap, 64'h0C00F);
`endif

    // FIFO full: 20 back-to-back writes, first pops at once, last three dropped
    set_cfg(100, 2'b11, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (i == 17) begin
        chk("full_cnt", 64'(fifo_cnt_o), 64'd16);
        chk("full_ready", 64'(ready_o), 64'd0);
      end
      valid_i = 1'b1;
      data_i  = 8'(8'h10 + i);
    end
    @(negedge clk_i);
    valid_i = 1'b0;
    wait_temt(20000);

    // Clear mid-frame with two bytes still queued
    set_cfg(3, 2'b11, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      valid_i = 1'b1;
      data_i  = 8'(8'hC3 + i);
    end
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (10) @(negedge clk_i);
    chk("clr_pre_cnt", 64'(fifo_cnt_o), 64'd2);
    fifo_clr_i = 1'b1;
    @(negedge clk_i);
    fifo_clr_i = 1'b0;
    chk("clr_cnt", 64'(fifo_cnt_o), 64'd0);
    chk("clr_frame_alive", 64'(temt_o), 64'd0);
    wait_temt(200);
    chk("clr_tx_idle", 64'(tx_o), 64'd1);

    // Reset in the middle of a data bit, then 1-cycle bits with div 0
    set_cfg(4, 2'b11, 1'b0, 1'b0, 1'b0);
    push_byte(8'h00);
    repeat (8) @(negedge clk_i);
    chk("pre_rst_tx", 64'(tx_o), 64'd0);
    rst_ni = 1'b0;
    #1;
    chk("async_rst_tx", 64'(tx_o), 64'd1);
    chk("async_rst_cnt", 64'(fifo_cnt_o), 64'd0);
    chk("async_rst_temt", 64'(temt_o), 64'd1);
    chk("async_rst_ready", 64'(ready_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    div_i  = '0;
    send_capture(8'hA5, 10, pre, cap);
    chk("div0_frame", cap, 64'h14B);
    chk("div0_temt", 64'(temt_o), 64'd1);

    // Randomized traffic, clears and mid-frame config changes
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk_i);
      valid_i    = ($urandom_range(0, 2) == 0);
      data_i     = 8'($urandom);
      fifo_clr_i = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 7) == 0) begin
        div_i         = DIV_W'($urandom_range(0, 3));
        word_len_i    = 2'($urandom);
        stop2_i       = 1'($urandom);
        parity_en_i   = 1'($urandom);
        parity_even_i = 1'($urandom);
      end
    end
    @(negedge clk_i);
    valid_i    = 1'b0;
    fifo_clr_i = 1'b0;
    wait_temt(5000);
    repeat (3) @(negedge clk_i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
